// File: rtl/binary_to_bcd.sv
// binary_to_bcd
//   Sequential double-dabble (shift-add-3) converter from a zero-extended
//   14-bit unsigned binary value to four packed BCD digits. Values above
//   9999 saturate to 9,9,9,9 and raise the overflow flag.
//
//   A conversion takes 15 clocks from the sampling edge to the done pulse.
//   The digit outputs are registered and change only on the done cycle,
//   so the display never sees intermediate scratch values.
//
// Ports
//   CLK            system clock, rising-edge active
//   RST_N          asynchronous active-low reset
//   start          one-cycle request, sampled only while idle
//   binaryInput    unsigned value to convert (IN_W bits, 4..14)
//   busy           high while a conversion is in progress
//   done           one-cycle pulse when the digit outputs update
//   overflow       1 if the last converted value was above 9999
//   BCD_THOUSANDS  thousands digit, 0..9
//   BCD_HUNDREDS   hundreds digit, 0..9
//   BCD_TENS       tens digit, 0..9
//   BCD_ONES       ones digit, 0..9

module binary_to_bcd #(
    parameter int IN_W = 14
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            start,
    input  logic [IN_W-1:0] binaryInput,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [3:0]      BCD_THOUSANDS,
    output logic [3:0]      BCD_HUNDREDS,
    output logic [3:0]      BCD_TENS,
    output logic [3:0]      BCD_ONES
);

    localparam int          VAL_W   = 14;
    localparam logic [VAL_W-1:0] MAX_VAL = 14'd9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [VAL_W-1:0]   shift_reg;
    logic [15:0]        scratch;
    logic [3:0]         cnt;
    logic               ovf_cap;
    logic [VAL_W-1:0]   in_ext;
    logic [15:0]        scratch_adj;

    // Add 3 to every nibble that is 5 or more, so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [15:0] add3(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [15:0] saturate(input logic ovf, input logic [15:0] bcd);
        return ovf ? 16'h9999 : bcd;
    endfunction

    always_comb begin
        in_ext             = '0;
        in_ext[IN_W-1:0]   = binaryInput;
    end

    always_comb begin
        scratch_adj = add3(scratch);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            shift_reg     <= '0;
            scratch       <= '0;
            cnt           <= '0;
            ovf_cap       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            BCD_THOUSANDS <= '0;
            BCD_HUNDREDS  <= '0;
            BCD_TENS      <= '0;
            BCD_ONES      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= in_ext;
                        scratch   <= '0;
                        cnt       <= 4'd14;
                        ovf_cap   <= (in_ext > MAX_VAL);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= {scratch_adj[14:0], shift_reg[VAL_W-1]};
                    shift_reg <= {shift_reg[VAL_W-2:0], 1'b0};
                    cnt       <= cnt - 4'd1;
                    // A carry out of the thousands nibble is only possible for
                    // values already above 9999, so it can never clear or
                    // contradict the captured overflow decision.
                    ovf_cap   <= ovf_cap | scratch_adj[15];
                    if (cnt == 4'd1)
                        state <= DONE;
                end
                DONE: begin
                    {BCD_THOUSANDS, BCD_HUNDREDS, BCD_TENS, BCD_ONES} <= saturate(ovf_cap, scratch);
                    overflow <= ovf_cap;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd.sv
// tb_binary_to_bcd
//   Directed bench for binary_to_bcd. A behavioural model (decimal arithmetic
//   plus a 15-cycle countdown) predicts busy/done/overflow/digits, and one
//   compare process checks the DUT against it on every falling edge. The
//   directed tasks also check hand-computed literal digits and latency.

module tb_binary_to_bcd;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [13:0] binaryInput;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  BCD_THOUSANDS;
    logic [3:0]  BCD_HUNDREDS;
    logic [3:0]  BCD_TENS;
    logic [3:0]  BCD_ONES;

    int vectors     = 0;
    int miscompares = 0;

    binary_to_bcd #(.IN_W(14)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .start         (start),
        .binaryInput   (binaryInput),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .BCD_THOUSANDS (BCD_THOUSANDS),
        .BCD_HUNDREDS  (BCD_HUNDREDS),
        .BCD_TENS      (BCD_TENS),
        .BCD_ONES      (BCD_ONES)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    int          m_left;
    int          m_val;
    logic        e_busy;
    logic        e_done;
    logic        e_ovf;
    logic [15:0] e_bcd;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_left <= 0;
            m_val  <= 0;
            e_busy <= 1'b0;
            e_done <= 1'b0;
            e_ovf  <= 1'b0;
            e_bcd  <= 16'h0000;
        end else begin
            e_done <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_val  <= int'(binaryInput);
                    m_left <= 15;
                    e_busy <= 1'b1;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    e_busy <= 1'b0;
                    e_done <= 1'b1;
                    e_bcd  <= to_bcd(m_val);
                    e_ovf  <= (m_val > 9999);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("digits", 32'({BCD_THOUSANDS, BCD_HUNDREDS, BCD_TENS, BCD_ONES}), 32'(e_bcd));
    end

    // ---------------- directed stimulus ----------------
    // Called at a falling edge; start is sampled by the next rising edge.
    task automatic pulse(input logic [13:0] v);
        start       = 1'b1;
        binaryInput = v;
        @(negedge CLK);
        start       = 1'b0;
        binaryInput = 14'($urandom);
    endtask

    task automatic wait_done(input string name, input logic [15:0] exp_bcd,
                             input logic exp_ovf, input int lat0);
        int lat;
        lat = lat0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd15);
        chk({name, "_digits"}, 32'({BCD_THOUSANDS, BCD_HUNDREDS, BCD_TENS, BCD_ONES}), 32'(exp_bcd));
        chk({name, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic run(input string name, input logic [13:0] v,
                       input logic [15:0] exp_bcd, input logic exp_ovf);
        pulse(v);
        wait_done(name, exp_bcd, exp_ovf, 0);
    endtask

    task automatic count_done(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge CLK);
            if (done === 1'b1) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        RST_N       = 1'b0;
        start       = 1'b0;
        binaryInput = '0;

        repeat (3) @(negedge CLK);
        chk("reset_digits", 32'({BCD_THOUSANDS, BCD_HUNDREDS, BCD_TENS, BCD_ONES}), 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        chk("idle_digits", 32'({BCD_THOUSANDS, BCD_HUNDREDS, BCD_TENS, BCD_ONES}), 32'h0);

        run("one",   14'd1,     16'h0001, 1'b0);
        run("v9889", 14'd9889,  16'h9889, 1'b0);
        run("v9999", 14'd9999,  16'h9999, 1'b0);
        run("zero",  14'd0,     16'h0000, 1'b0);
        run("v1000", 14'd1000,  16'h1000, 1'b0);
        run("v909",  14'd909,   16'h0909, 1'b0);
        run("v10000", 14'd10000, 16'h9999, 1'b1);
        run("v16383", 14'd16383, 16'h9999, 1'b1);
        run("v42",   14'd42,    16'h0042, 1'b0);
        repeat (3) @(negedge CLK);

        // Second start while busy must be ignored.
        pulse(14'd1234);
        repeat (4) @(negedge CLK);
        pulse(14'd5678);
        wait_done("busy_start", 16'h1234, 1'b0, 5);
        count_done("single_done", 20);

        // Back-to-back: second start sampled exactly one edge after done.
        run("b2b_a", 14'd2468, 16'h2468, 1'b0);
        run("b2b_b", 14'd1357, 16'h1357, 1'b0);
        repeat (2) @(negedge CLK);

        // Reset in the middle of a conversion aborts it.
        pulse(14'd4321);
        repeat (6) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("abort_digits", 32'({BCD_THOUSANDS, BCD_HUNDREDS, BCD_TENS, BCD_ONES}), 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        count_done("abort_no_done", 20);
        run("v4321", 14'd4321, 16'h4321, 1'b0);

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd.md
Name: binary_to_bcd

Overview:
- Converts a 14-bit unsigned binary value (0..16383) to four packed BCD digits: thousands, hundreds, tens and ones.
- Uses a sequential double-dabble (shift-add-3) engine with a start/done handshake.
- Sits between step/metric counters and the seven-segment display driver in the Fitbit replica.
- Saturates inputs above 9999 to 9999 and flags the overflow.

Parameters:
- IN_W, 14, width of the binary input. Legal values 4..14. Output digit count is fixed at 4.

Ports:
- CLK  input  1  system clock, rising-edge active
- RST_N  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; samples binaryInput when the block is idle
- binaryInput  input  IN_W  unsigned value to convert
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the digit outputs update
- overflow  output  1  registered; 1 if the last converted input was > 9999
- BCD_THOUSANDS  output  4  thousands digit, 0..9
- BCD_HUNDREDS  output  4  hundreds digit, 0..9
- BCD_TENS  output  4  tens digit, 0..9
- BCD_ONES  output  4  ones digit, 0..9

Behaviour:
- Reset (RST_N low, asynchronous):
  - all outputs go to 0; state goes to IDLE; internal shift and BCD registers clear.
  - Reset asserted mid-conversion aborts the conversion; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at a rising edge captures binaryInput zero-extended to 14 bits.
  - At that same edge: clears the BCD scratch register, sets the shift counter to 14, sets busy=1, goes to SHIFT.
- SHIFT, one iteration per clock:
  - First, each scratch nibble >= 5 gets 3 added.
  - Then {scratch, shift reg} shifts left 1 bit and the counter decrements.
  - After the 14th iteration, go to DONE.
- DONE (one cycle):
  - If the captured value > 9999: outputs = 9,9,9,9 and overflow=1.
  - Otherwise: outputs = scratch digits and overflow=0.
  - done=1 for exactly this cycle; busy drops to 0; return to IDLE.
- Latency:
  - start sampled at edge N; outputs and done are valid after edge N+15; a new start is accepted at edge N+16.
- start is ignored while busy=1. binaryInput may change freely after the capture edge.
- Outputs hold their last converted value until the next DONE; they never show intermediate scratch values.
- Every output digit is always within 0..9.
- Overflow check compares the captured 14-bit value against the constant 9999 (14'd9999).
- Fully synchronous except reset; no latches, no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: RST_N low -> all digits 0, done=0, busy=0, overflow=0. Release RST_N; no start -> outputs stay 0.
- Input 1, pulse start -> done exactly 15 cycles after the sample edge; digits 0,0,0,1; overflow=0; busy high for 15 cycles.
- Boundary values: 9889 -> 9,8,8,9; 9999 -> 9,9,9,9 with overflow=0; 0 -> 0,0,0,0; 1000 -> 1,0,0,0; 909 -> 0,9,0,9.
- Overflow: 10000 -> 9,9,9,9 with overflow=1; 16383 -> 9,9,9,9 with overflow=1. A following conversion of 42 -> 0,0,4,2 with overflow=0.
- Start during busy: start 1234, then pulse start with 5678 at cycle 5 -> ignored; result 1,2,3,4 with a single done pulse. Back-to-back starts at edges N and N+16 produce two correct results.
- Reset mid-operation: assert RST_N low at cycle 7 of a 4321 conversion -> outputs 0, no done. After release, a fresh conversion of 4321 -> 4,3,2,1.
